// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-controller port between fetch (req0) and LSU (req1).
// Define MEM_ARB_RR_EN for round-robin tie-break instead of fixed priority with starvation limit.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic        req1_we,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_be,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enables,
  input  logic [31:0] mem_read_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic gid, lwe, pick, grant, wr;
  logic [3:0] cnt;
`ifdef MEM_ARB_RR_EN
  logic ptr;
  always_comb pick = (req0_valid && req1_valid) ? ~ptr : !req0_valid;
`else
  logic [3:0] starve;
  always_comb pick = !(req0_valid && (!req1_valid || starve == 4'(STARVE_LIMIT)));
`endif
  // ready is gated by rst so every output reads 0 while reset is held
  assign grant = rst && state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = grant && !pick;
  assign req1_ready = grant && pick;
  assign wr = pick && req1_we;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gid <= 1'b0;
      lwe <= 1'b0;
      cnt <= '0;
`ifdef MEM_ARB_RR_EN
      ptr <= 1'b0;
`else
      starve <= '0;
`endif
      mem_address <= '0;
      mem_read_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_data <= '0;
      mem_byte_enables <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data <= '0;
    end else begin
      mem_address <= '0;
      mem_read_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_data <= '0;
      mem_byte_enables <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data <= '0;
      case (state)
        IDLE: if (grant) begin
          gid <= pick;
          lwe <= wr;
          mem_address <= pick ? req1_addr : req0_addr;
          mem_read_enable <= !wr;
          mem_write_enable <= wr;
          mem_write_data <= wr ? req1_wdata : '0;
          mem_byte_enables <= wr ? req1_be : 4'hF;
`ifdef MEM_ARB_RR_EN
          ptr <= pick;
`else
          if (!pick) starve <= '0;
          else if (req0_valid && starve != 4'hF) starve <= starve + 4'd1;
`endif
          state <= ISSUE;
        end
        ISSUE: begin
          state <= lwe ? RESP : WAIT;
          cnt <= 4'(MEM_LAT - 1);
          rsp1_valid <= lwe;
        end
        WAIT: if (cnt == 4'd0) begin
          state <= RESP;
          rsp0_valid <= !gid;
          rsp1_valid <= gid;
          rsp0_data <= gid ? '0 : mem_read_data;
          rsp1_data <= gid ? mem_read_data : '0;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks on three arbiters (MEM_LAT 1/3/4) sharing request inputs.
module tb_mem_port_arbiter;
  logic clk, rst, req0_valid, req1_valid, req1_we;
  logic [31:0] req0_addr, req1_addr, req1_wdata;
  logic [3:0] req1_be;
  logic req0_ready [3], rsp0_valid [3], req1_ready [3], rsp1_valid [3];
  logic mem_read_enable [3], mem_write_enable [3], busy [3];
  logic [31:0] rsp0_data [3], rsp1_data [3], mem_address [3], mem_write_data [3];
  logic [3:0] mem_byte_enables [3];
  int total, bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : gi
    localparam int LAT = g == 0 ? 1 : g == 1 ? 3 : 4;
    logic [4:0] mc;
    logic [31:0] ma, rd;
    // memory model: data is valid only in the cycle LAT after the read pulse
    assign rd = mc == 5'd1 ? mem_word(ma) : 32'hBAD0_BAD0;
    always @(posedge clk) begin
      if (!rst) mc <= 5'd0;
      else if (mem_read_enable[g]) begin
        mc <= 5'(LAT);
        ma <= mem_address[g];
      end else if (mc != 5'd0) mc <= mc - 5'd1;
    end
    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(g == 0 ? 2 : 4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready[g]),
      .rsp0_valid(rsp0_valid[g]), .rsp0_data(rsp0_data[g]),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we),
      .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(req1_ready[g]),
      .rsp1_valid(rsp1_valid[g]), .rsp1_data(rsp1_data[g]),
      .mem_address(mem_address[g]), .mem_read_enable(mem_read_enable[g]),
      .mem_write_enable(mem_write_enable[g]), .mem_write_data(mem_write_data[g]),
      .mem_byte_enables(mem_byte_enables[g]), .mem_read_data(rd), .busy(busy[g])
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_we = 1'b0; req1_wdata = '0; req1_be = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset_state();
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (busy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
      total++; if (req0_ready[i] !== 1'b0 || req1_ready[i] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b%b want 00", i, req0_ready[i], req1_ready[i]); end
    end
    total++; if (mem_read_enable[0] !== 1'b0 || mem_write_enable[0] !== 1'b0) begin bad++; $display("FAIL reset_mem_en: got %b%b want 00", mem_read_enable[0], mem_write_enable[0]); end
    clear_inputs();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic seen;
    cyc();
    req0_valid = 1'b1; req0_addr = 32'h100;
    #1;
    total++; if (req0_ready[1] !== 1'b1) begin bad++; $display("FAIL rst_mid_accept: got %b want 1", req0_ready[1]); end
    cyc();
    req0_valid = 1'b0;
    #1;
    total++; if (mem_read_enable[1] !== 1'b1 || mem_address[1] !== 32'h100) begin bad++; $display("FAIL rst_mid_issue: got re=%b addr=%h want re=1 addr=00000100", mem_read_enable[1], mem_address[1]); end
    cyc();
    #1;
    total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL rst_mid_wait_busy: got %b want 1", busy[1]); end
    rst = 1'b0;
    req0_valid = 1'b1;
    #1;
    total++; if (busy[1] !== 1'b0 || req0_ready[1] !== 1'b0 || mem_address[1] !== 32'h0 || rsp0_valid[1] !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs: got busy=%b rdy=%b addr=%h rsp=%b want all 0", busy[1], req0_ready[1], mem_address[1], rsp0_valid[1]); end
    cyc();
    req0_valid = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (rsp0_valid[1] || busy[1]) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_dropped: got activity=%b want 0", seen); end
    req0_valid = 1'b1; req0_addr = 32'h104;
    #1;
    total++; if (req0_ready[1] !== 1'b1) begin bad++; $display("FAIL rst_after_accept: got %b want 1", req0_ready[1]); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      req0_valid = 1'b0;
      #1;
      total++; if (rsp0_valid[1] !== (k == 5)) begin bad++; $display("FAIL rst_after_rsp k=%0d: got %b want %b", k, rsp0_valid[1], k == 5); end
      if (k == 5) begin
        total++; if (rsp0_data[1] !== mem_word(32'h104)) begin bad++; $display("FAIL rst_after_data: got %h want %h", rsp0_data[1], mem_word(32'h104)); end
      end
    end
  endtask

  task automatic test_fetch();
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h40;
    #1;
    total++; if (req0_ready[0] !== 1'b1 || req1_ready[0] !== 1'b0) begin bad++; $display("FAIL fetch_ready: got %b%b want 10", req0_ready[0], req1_ready[0]); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      req0_valid = 1'b0;
      #1;
      total++; if (mem_read_enable[0] !== (k == 1)) begin bad++; $display("FAIL fetch_re k=%0d: got %b want %b", k, mem_read_enable[0], k == 1); end
      if (k == 1) begin
        total++; if (mem_address[0] !== 32'h40 || mem_byte_enables[0] !== 4'hF) begin bad++; $display("FAIL fetch_addr_be: got %h/%h want 00000040/f", mem_address[0], mem_byte_enables[0]); end
      end
      total++; if (rsp0_valid[0] !== (k == 3)) begin bad++; $display("FAIL fetch_rsp k=%0d: got %b want %b", k, rsp0_valid[0], k == 3); end
      if (k == 3) begin
        total++; if (rsp0_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_data: got %h want deadbeef", rsp0_data[0]); end
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h80; req1_wdata = 32'h12345678; req1_be = 4'b0011;
    #1;
    total++; if (req1_ready[0] !== 1'b1) begin bad++; $display("FAIL write_ready: got %b want 1", req1_ready[0]); end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      clear_inputs();
      #1;
      total++; if (mem_write_enable[0] !== (k == 1) || mem_read_enable[0] !== 1'b0) begin bad++; $display("FAIL write_en k=%0d: got we=%b re=%b want we=%b re=0", k, mem_write_enable[0], mem_read_enable[0], k == 1); end
      if (k == 1) begin
        total++; if (mem_address[0] !== 32'h80 || mem_write_data[0] !== 32'h12345678 || mem_byte_enables[0] !== 4'b0011) begin bad++; $display("FAIL write_payload: got %h %h %h want 00000080 12345678 3", mem_address[0], mem_write_data[0], mem_byte_enables[0]); end
      end
      total++; if (rsp1_valid[0] !== (k == 2) || rsp0_valid[0] !== 1'b0) begin bad++; $display("FAIL write_ack k=%0d: got rsp1=%b rsp0=%b want rsp1=%b rsp0=0", k, rsp1_valid[0], rsp0_valid[0], k == 2); end
      if (k == 2) begin
        total++; if (rsp1_data[0] !== 32'h0) begin bad++; $display("FAIL write_ack_data: got %h want 0", rsp1_data[0]); end
      end
    end
  endtask

  task automatic test_arb();
    int n;
    logic lg, ex;
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h300;
    req1_valid = 1'b1; req1_addr = 32'h400;
    n = 0;
    lg = 1'b0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #1;
      if (req0_ready[0] && req1_ready[0]) begin total++; bad++; $display("FAIL arb_both_ready: got 11 want one-hot"); end
      if (req0_ready[0] || req1_ready[0]) begin
`ifdef MEM_ARB_RR_EN
        ex = n % 2 == 0;
`else
        ex = n % 3 != 2;
`endif
        total++; if (req1_ready[0] !== ex) begin bad++; $display("FAIL arb_grant n=%0d: got %b want %b", n, req1_ready[0], ex); end
        lg = req1_ready[0];
        n++;
      end
      if (rsp0_valid[0]) begin
        total++; if (lg !== 1'b0 || rsp1_valid[0] !== 1'b0 || rsp0_data[0] !== mem_word(32'h300)) begin bad++; $display("FAIL arb_rsp0: got grant=%b data=%h want grant=0 data=%h", lg, rsp0_data[0], mem_word(32'h300)); end
      end
      if (rsp1_valid[0]) begin
        total++; if (lg !== 1'b1 || rsp1_data[0] !== mem_word(32'h400)) begin bad++; $display("FAIL arb_rsp1: got grant=%b data=%h want grant=1 data=%h", lg, rsp1_data[0], mem_word(32'h400)); end
      end
      cyc();
    end
    total++; if (n !== 6) begin bad++; $display("FAIL arb_grant_count: got %0d want 6", n); end
    clear_inputs();
  endtask

  task automatic test_lat();
    do_reset();
    req1_valid = 1'b1; req1_addr = 32'h200; req1_we = 1'b0; req1_be = 4'hF;
    #1;
    total++; if (req1_ready[2] !== 1'b1) begin bad++; $display("FAIL lat_accept: got %b want 1", req1_ready[2]); end
    for (int k = 1; k <= 7; k++) begin
      cyc();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 32'h500;
      #1;
      total++; if (busy[2] !== (k <= 6)) begin bad++; $display("FAIL lat_busy k=%0d: got %b want %b", k, busy[2], k <= 6); end
      total++; if (req0_ready[2] !== (k == 7)) begin bad++; $display("FAIL lat_req0_ready k=%0d: got %b want %b", k, req0_ready[2], k == 7); end
      total++; if (rsp1_valid[2] !== (k == 6)) begin bad++; $display("FAIL lat_rsp1 k=%0d: got %b want %b", k, rsp1_valid[2], k == 6); end
      if (k == 6) begin
        total++; if (rsp1_data[2] !== mem_word(32'h200)) begin bad++; $display("FAIL lat_data: got %h want %h", rsp1_data[2], mem_word(32'h200)); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset_state();
    test_reset();
    test_fetch();
    test_write();
    test_arb();
    test_lat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
